l1_stream_credit_ptr: RTL and testbench
=======================================

Name: l1_stream_credit_ptr

Overview:
Per-stream L1 read-pointer and refill-credit controller, one instance per stream.
- Generalises the per-stream pointer tracker: multi-port grant with per-port addresses, configurable prefill depth, bounded outstanding L2 refills, and a functional stream reset that is legal mid-operation.
- Sits between the L1 read-port arbitration (transposed per-stream valid/ready) and the L2 refill request/response interface.

Parameters:
- nports, 8, read ports; must satisfy nports <= cl_size.
- ncl, 16, cachelines held per stream (power of two).
- cl_size, 8, reads per cacheline (power of two).
- init_lines, 2, lines that must be filled before a reset completes (1..ncl).
- max_outst, 4, maximum outstanding L2 refill requests (1..ncl).
- clid_width, $clog2(ncl), cacheline index width.
- clofs_width, $clog2(cl_size), offset width.
- ptr_width, clid_width+clofs_width, stream pointer width.
- cnt_width, $clog2(ncl+1), line-counter width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- i_rst_v, in, 1, functional stream reset request.
- i_rst_r, out, 1, reset request accepted.
- i_rst_ea_b, in, clid_width, start cacheline index.
- o_rst_v, out, 1, reset complete (prefill done).
- o_rst_r, in, 1, completion acknowledged.
- i_rd_v, in, nports, per-port read request for this stream.
- i_rd_r, out, nports, per-port grant.
- o_rd_ptr, out, nports*ptr_width, per-port read pointer (slice k belongs to port k).
- o_ptr, out, ptr_width, current head pointer.
- o_active, out, 1, stream accepting reads.
- o_clreq_v, out, 1, L2 cacheline refill request.
- o_clreq_r, in, 1, refill request accepted.
- i_clrsp_v, in, 1, refill line written into L1.
- i_clrsp_r, out, 1, refill response accepted; tied to 1.

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE; rd_ptr, valid_lines, out_cnt, issued all 0; o_rst_v=0, o_clreq_v=0, i_rd_r=0, o_active=0.
- States:
  - IDLE: waiting for a functional stream reset.
  - FILL: issuing prefill refills.
  - DONE: o_rst_v=1, waiting for o_rst_r.
  - ACTIVE: serving reads and refilling.
- i_rst_r = (state is IDLE or ACTIVE) && out_cnt==0.
- On the i_rst handshake: rd_ptr={i_rst_ea_b,0}, valid_lines=0, issued=0, next state FILL. Any pending reads are dropped.
- In ACTIVE with i_rst_v=1 and out_cnt>0: o_clreq_v is forced 0 and reads continue. The reset is accepted in the first cycle out_cnt reaches 0.
- o_clreq_v = (state is FILL or ACTIVE) && !(ACTIVE && i_rst_v) && out_cnt<max_outst && (valid_lines+out_cnt)<ncl.
- Refill request handshake: out_cnt+1. Refill response: out_cnt-1, valid_lines+1. Both in the same cycle: out_cnt unchanged, valid_lines+1.
- FILL -> DONE when valid_lines (registered) >= init_lines. DONE -> ACTIVE on o_rst_r. Refill requests continue in FILL only; in DONE o_clreq_v=0 while responses are still absorbed.
- avail = valid_lines*cl_size - rd_ptr[clofs_width-1:0], evaluated only in ACTIVE (0 otherwise).
- Grant rule: pre_k = popcount(i_rd_v[k-1:0]). i_rd_r[k] = ACTIVE && i_rd_v[k] && pre_k < avail. Grants are lowest-index first; i_rd_r is combinational from i_rd_v.
- o_rd_ptr slice k = (rd_ptr + pre_k) mod 2^ptr_width for every k; the value is valid only when granted.
- Update: g = number of grants; rd_ptr += g (mod 2^ptr_width, wraps naturally).
- Retire: if offset+g >= cl_size, exactly one line is retired and valid_lines-1 in that cycle. This nets with a simultaneous refill response.
- o_ptr = rd_ptr. o_active = (state==ACTIVE).
- Zero-latency grant; state updates on the next edge.
- Assertions: valid_lines+out_cnt <= ncl; i_clrsp_v never arrives with out_cnt==0.

Test Plan:
Bench config for all scenarios: nports=4, ncl=4, cl_size=8, init_lines=2, max_outst=2, ptr_width=5.
1. Reset with ea_b=3, then two refill request/response pairs -> o_rst_v=1 after valid_lines=2. After o_rst_r: o_active=1, o_ptr=24, o_clreq_v remains 1 until 4 lines are held or outstanding.
2. ACTIVE with avail>=4, i_rd_v=4'b1111 -> i_rd_r=4'b1111, o_rd_ptr slices 24,25,26,27; next o_ptr=28.
3. Pointer wrap: rd_ptr=30, i_rd_v=4'b1011, lines valid -> slices used: port0=30, port1=31, port3=0. Next rd_ptr=1; one line retired.
4. Starvation: valid_lines=1, offset=5 (avail=3), i_rd_v=4'b1111 -> i_rd_r=4'b0111, rd_ptr+3, valid_lines 1->0, o_clreq_v=1 next cycle.
5. Same-cycle refill response and line retire -> valid_lines unchanged, out_cnt-1, no assertion fires.
6. Mid-operation reset with out_cnt=1: i_rst_v held -> i_rst_r=0 and o_clreq_v=0 until the response arrives. Accepted the following cycle: o_active=0, rd_ptr={ea_b,0}, state FILL.

Source files
------------

// File: rtl/l1_stream_credit_ptr.sv
// Per-stream L1 read-pointer and refill-credit controller: grants multi-port reads
// against the lines currently held in L1 and keeps a bounded number of L2 refills in flight.
//
// state  | meaning
// IDLE   | waiting for a functional stream reset
// FILL   | issuing prefill refills until init_lines are held
// DONE   | prefill complete, o_rst_v high until acknowledged
// ACTIVE | serving reads and refilling
module l1_stream_credit_ptr #(
    parameter int nports      = 8,
    parameter int ncl         = 16,
    parameter int cl_size     = 8,
    parameter int init_lines  = 2,
    parameter int max_outst   = 4,
    parameter int clid_width  = $clog2(ncl),
    parameter int clofs_width = $clog2(cl_size),
    parameter int ptr_width   = clid_width + clofs_width,
    parameter int cnt_width   = $clog2(ncl + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_rst_v,
    output logic                        i_rst_r,
    input  logic [clid_width-1:0]       i_rst_ea_b,
    output logic                        o_rst_v,
    input  logic                        o_rst_r,
    input  logic [nports-1:0]           i_rd_v,
    output logic [nports-1:0]           i_rd_r,
    output logic [nports*ptr_width-1:0] o_rd_ptr,
    output logic [ptr_width-1:0]        o_ptr,
    output logic                        o_active,
    output logic                        o_clreq_v,
    input  logic                        o_clreq_r,
    input  logic                        i_clrsp_v,
    output logic                        i_clrsp_r
);

    localparam int aw = ptr_width + 1;
    localparam int pw = $clog2(nports + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2, ACTIVE = 2'd3} state_t;

    state_t               state, state_n;
    logic [ptr_width-1:0] rd_ptr;
    logic [cnt_width-1:0] valid_lines, out_cnt, issued;
    logic [pw-1:0]        pre [nports];
    logic [pw-1:0]        grant_cnt;
    logic [aw-1:0]        line_words, offset_ext, avail;
    logic                 active, rst_fire, req_fire, retire;

    assign active    = (state == ACTIVE);
    assign i_rst_r   = ((state == IDLE) || active) && (out_cnt == '0);
    assign rst_fire  = i_rst_v && i_rst_r;
    // A pending stream reset in ACTIVE stops new refills so out_cnt can drain to zero.
    assign o_clreq_v = ((state == FILL) || (active && !i_rst_v))
                       && (out_cnt < cnt_width'(max_outst))
                       && (({1'b0, valid_lines} + {1'b0, out_cnt}) < (cnt_width + 1)'(ncl));
    assign req_fire  = o_clreq_v && o_clreq_r;
    assign i_clrsp_r = 1'b1;
    assign o_rst_v   = (state == DONE);
    assign o_ptr     = rd_ptr;
    assign o_active  = active;

    assign line_words = aw'(valid_lines) << clofs_width;
    assign offset_ext = aw'(rd_ptr[clofs_width-1:0]);
    assign avail      = (active && (line_words >= offset_ext)) ? (line_words - offset_ext) : '0;

    always_comb begin
        pre[0] = '0;
        for (int k = 1; k < nports; k++) begin
            pre[k] = pre[k-1] + pw'(i_rd_v[k-1]);
        end
    end

    // Reads presented in the cycle a stream reset is accepted are dropped.
    always_comb begin
        i_rd_r    = '0;
        grant_cnt = '0;
        o_rd_ptr  = '0;
        for (int k = 0; k < nports; k++) begin
            o_rd_ptr[k*ptr_width +: ptr_width] = rd_ptr + ptr_width'(pre[k]);
            if (active && !rst_fire && i_rd_v[k] && (aw'(pre[k]) < avail)) begin
                i_rd_r[k] = 1'b1;
                grant_cnt = grant_cnt + pw'(1);
            end
        end
    end

    assign retire = (offset_ext + aw'(grant_cnt)) >= aw'(cl_size);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (rst_fire) state_n = FILL;
            FILL:    if (valid_lines >= cnt_width'(init_lines)) state_n = DONE;
            DONE:    if (o_rst_r) state_n = ACTIVE;
            ACTIVE:  if (rst_fire) state_n = FILL;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            valid_lines <= '0;
            out_cnt     <= '0;
            issued      <= '0;
        end else begin
            state   <= state_n;
            out_cnt <= out_cnt + cnt_width'(req_fire) - cnt_width'(i_clrsp_v);
            if (rst_fire) begin
                rd_ptr      <= {i_rst_ea_b, {clofs_width{1'b0}}};
                valid_lines <= '0;
                issued      <= '0;
            end else begin
                rd_ptr      <= rd_ptr + ptr_width'(grant_cnt);
                valid_lines <= valid_lines + cnt_width'(i_clrsp_v) - cnt_width'(retire);
                if (req_fire && (issued != cnt_width'(ncl))) begin
                    issued <= issued + cnt_width'(1);
                end
            end
        end
    end

    a_line_budget: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, valid_lines} + {1'b0, out_cnt}) <= (cnt_width + 1)'(ncl));
    a_rsp_credit: assert property (@(posedge clk) disable iff (reset)
        i_clrsp_v |-> (out_cnt != '0));
    a_outst_issued: assert property (@(posedge clk) disable iff (reset)
        out_cnt <= issued);

endmodule

// File: tb/tb_l1_stream_credit_ptr.sv
// Scenario bench for l1_stream_credit_ptr: a small line/pointer model feeds a
// scoreboard of expected grants and pointer slices, plus fixed-value scenario checks.
module tb_l1_stream_credit_ptr;
    localparam int NP  = 4;
    localparam int NCL = 4;
    localparam int CLS = 8;
    localparam int PW  = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            i_rst_v, i_rst_r, o_rst_v, o_rst_r;
    logic [1:0]      i_rst_ea_b;
    logic [NP-1:0]   i_rd_v, i_rd_r;
    logic [NP*PW-1:0] o_rd_ptr;
    logic [PW-1:0]   o_ptr;
    logic            o_active, o_clreq_v, o_clreq_r, i_clrsp_v, i_clrsp_r;

    int checks = 0;
    int failures = 0;
    int m_vl, m_oc, m_ptr;

    typedef struct packed {
        logic [NP-1:0]    mask;
        logic [NP*PW-1:0] ptrs;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    l1_stream_credit_ptr #(
        .nports(NP), .ncl(NCL), .cl_size(CLS), .init_lines(2), .max_outst(2)
    ) dut (
        .clk(clk), .reset(reset),
        .i_rst_v(i_rst_v), .i_rst_r(i_rst_r), .i_rst_ea_b(i_rst_ea_b),
        .o_rst_v(o_rst_v), .o_rst_r(o_rst_r),
        .i_rd_v(i_rd_v), .i_rd_r(i_rd_r), .o_rd_ptr(o_rd_ptr),
        .o_ptr(o_ptr), .o_active(o_active),
        .o_clreq_v(o_clreq_v), .o_clreq_r(o_clreq_r),
        .i_clrsp_v(i_clrsp_v), .i_clrsp_r(i_clrsp_r)
    );

    // One read cycle: expectation derived from the model, pushed, then popped at the sample point.
    task automatic do_read(input logic [NP-1:0] v, input logic rsp,
                           output logic [NP-1:0] got_r, output logic [NP*PW-1:0] got_p);
        exp_t e;
        exp_t x;
        int avail, cnt, g;
        avail = m_vl * CLS - (m_ptr % CLS);
        if (avail < 0) avail = 0;
        cnt = 0;
        e.mask = '0;
        e.ptrs = '0;
        for (int k = 0; k < NP; k++) begin
            e.ptrs[k*PW +: PW] = PW'((m_ptr + cnt) % 32);
            if (v[k]) begin
                if (cnt < avail) e.mask[k] = 1'b1;
                cnt++;
            end
        end
        sb.push_back(e);
        i_rd_v = v;
        i_clrsp_v = rsp;
        @(negedge clk);
        x = sb.pop_front();
        got_r = i_rd_r;
        got_p = o_rd_ptr;
        checks++;
        if (i_rd_r !== x.mask) begin
            failures++;
            $display("FAIL sb_grant got=%b exp=%b", i_rd_r, x.mask);
        end
        for (int k = 0; k < NP; k++) begin
            if (x.mask[k]) begin
                checks++;
                if (o_rd_ptr[k*PW +: PW] !== x.ptrs[k*PW +: PW]) begin
                    failures++;
                    $display("FAIL sb_slice%0d got=%0d exp=%0d", k, o_rd_ptr[k*PW +: PW], x.ptrs[k*PW +: PW]);
                end
            end
        end
        @(posedge clk); #1;
        g = 0;
        for (int k = 0; k < NP; k++) if (x.mask[k]) g++;
        if ((m_ptr % CLS) + g >= CLS) m_vl--;
        m_ptr = (m_ptr + g) % 32;
        if (rsp) begin
            m_vl++;
            m_oc--;
        end
        i_rd_v = '0;
        i_clrsp_v = 1'b0;
    endtask

    task automatic refill_req();
        o_clreq_r = 1'b1;
        @(negedge clk);
        checks++;
        if (o_clreq_v !== 1'b1) begin
            failures++;
            $display("FAIL clreq_offer got=%b exp=1", o_clreq_v);
        end
        @(posedge clk); #1;
        o_clreq_r = 1'b0;
        if (o_clreq_v === 1'b1) m_oc++;
    endtask

    task automatic refill_rsp();
        i_clrsp_v = 1'b1;
        @(posedge clk); #1;
        i_clrsp_v = 1'b0;
        m_oc--;
        m_vl++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_rst_v = 1'b0; i_rst_ea_b = 2'd0; o_rst_r = 1'b0;
        i_rd_v = 4'hF; o_clreq_r = 1'b0; i_clrsp_v = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (o_rst_v !== 1'b0) begin failures++; $display("FAIL rst_o_rst_v got=%b exp=0", o_rst_v); end
        checks++; if (o_clreq_v !== 1'b0) begin failures++; $display("FAIL rst_clreq got=%b exp=0", o_clreq_v); end
        checks++; if (i_rd_r !== 4'b0000) begin failures++; $display("FAIL rst_grant got=%b exp=0000", i_rd_r); end
        checks++; if (o_active !== 1'b0) begin failures++; $display("FAIL rst_active got=%b exp=0", o_active); end
        checks++; if (o_ptr !== 5'd0) begin failures++; $display("FAIL rst_ptr got=%0d exp=0", o_ptr); end
        @(posedge clk); #1;
        reset = 1'b0;
        i_rd_v = '0;
        @(negedge clk);
        checks++; if (i_rst_r !== 1'b1) begin failures++; $display("FAIL idle_rst_r got=%b exp=1", i_rst_r); end
        checks++; if (i_clrsp_r !== 1'b1) begin failures++; $display("FAIL clrsp_r got=%b exp=1", i_clrsp_r); end
        @(posedge clk); #1;
        m_vl = 0; m_oc = 0; m_ptr = 0;
    endtask

    task automatic test_fill();
        i_rst_v = 1'b1; i_rst_ea_b = 2'd3;
        @(negedge clk);
        checks++; if (i_rst_r !== 1'b1) begin failures++; $display("FAIL fill_rst_r got=%b exp=1", i_rst_r); end
        @(posedge clk); #1;
        i_rst_v = 1'b0;
        m_ptr = 24;
        @(negedge clk);
        checks++; if (o_clreq_v !== 1'b1) begin failures++; $display("FAIL fill_clreq got=%b exp=1", o_clreq_v); end
        checks++; if (o_ptr !== 5'd24) begin failures++; $display("FAIL fill_ptr got=%0d exp=24", o_ptr); end
        checks++; if (o_active !== 1'b0) begin failures++; $display("FAIL fill_active got=%b exp=0", o_active); end
        @(posedge clk); #1;
        refill_req(); refill_rsp();
        refill_req(); refill_rsp();
        @(posedge clk); #1;
        o_rst_r = 1'b1;
        @(negedge clk);
        checks++; if (o_rst_v !== 1'b1) begin failures++; $display("FAIL done_rst_v got=%b exp=1", o_rst_v); end
        checks++; if (o_clreq_v !== 1'b0) begin failures++; $display("FAIL done_clreq got=%b exp=0", o_clreq_v); end
        @(posedge clk); #1;
        o_rst_r = 1'b0;
        @(negedge clk);
        checks++; if (o_active !== 1'b1) begin failures++; $display("FAIL act_active got=%b exp=1", o_active); end
        checks++; if (o_ptr !== 5'd24) begin failures++; $display("FAIL act_ptr got=%0d exp=24", o_ptr); end
        checks++; if (o_rst_v !== 1'b0) begin failures++; $display("FAIL act_rst_v got=%b exp=0", o_rst_v); end
        @(posedge clk); #1;
        refill_req(); refill_req();
        @(negedge clk);
        checks++; if (o_clreq_v !== 1'b0) begin failures++; $display("FAIL outst_cap got=%b exp=0", o_clreq_v); end
        @(posedge clk); #1;
        refill_rsp(); refill_rsp();
        @(negedge clk);
        checks++; if (o_clreq_v !== 1'b0) begin failures++; $display("FAIL lines_full got=%b exp=0", o_clreq_v); end
        @(posedge clk); #1;
    endtask

    task automatic test_burst();
        logic [NP-1:0] r;
        logic [NP*PW-1:0] p;
        do_read(4'b1111, 1'b0, r, p);
        checks++; if (r !== 4'b1111) begin failures++; $display("FAIL burst_grant got=%b exp=1111", r); end
        checks++; if (p !== {5'd27, 5'd26, 5'd25, 5'd24}) begin failures++; $display("FAIL burst_slices got=%h exp=%h", p, {5'd27, 5'd26, 5'd25, 5'd24}); end
        @(negedge clk);
        checks++; if (o_ptr !== 5'd28) begin failures++; $display("FAIL burst_ptr got=%0d exp=28", o_ptr); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        logic [NP-1:0] r;
        logic [NP*PW-1:0] p;
        do_read(4'b0011, 1'b0, r, p);
        do_read(4'b1011, 1'b0, r, p);
        checks++; if (r !== 4'b1011) begin failures++; $display("FAIL wrap_grant got=%b exp=1011", r); end
        checks++; if ({p[15 +: 5], p[5 +: 5], p[0 +: 5]} !== {5'd0, 5'd31, 5'd30}) begin
            failures++; $display("FAIL wrap_slices got=%0d,%0d,%0d exp=30,31,0", p[0 +: 5], p[5 +: 5], p[15 +: 5]);
        end
        @(negedge clk);
        checks++; if (o_ptr !== 5'd1) begin failures++; $display("FAIL wrap_ptr got=%0d exp=1", o_ptr); end
        checks++; if (o_clreq_v !== 1'b1) begin failures++; $display("FAIL wrap_retire_clreq got=%b exp=1", o_clreq_v); end
        @(posedge clk); #1;
    endtask

    task automatic test_starve();
        logic [NP-1:0] r;
        logic [NP*PW-1:0] p;
        do_read(4'b1111, 1'b0, r, p);
        do_read(4'b0111, 1'b0, r, p);
        do_read(4'b1111, 1'b0, r, p);
        do_read(4'b1111, 1'b0, r, p);
        do_read(4'b1111, 1'b0, r, p);
        do_read(4'b0001, 1'b0, r, p);
        do_read(4'b1111, 1'b0, r, p);
        checks++; if (r !== 4'b0111) begin failures++; $display("FAIL starve_grant got=%b exp=0111", r); end
        checks++; if (p[0 +: 15] !== {5'd23, 5'd22, 5'd21}) begin failures++; $display("FAIL starve_slices got=%h exp=%h", p[0 +: 15], {5'd23, 5'd22, 5'd21}); end
        @(negedge clk);
        checks++; if (o_ptr !== 5'd24) begin failures++; $display("FAIL starve_ptr got=%0d exp=24", o_ptr); end
        checks++; if (o_clreq_v !== 1'b1) begin failures++; $display("FAIL starve_clreq got=%b exp=1", o_clreq_v); end
        @(posedge clk); #1;
        do_read(4'b1111, 1'b0, r, p);
        checks++; if (r !== 4'b0000) begin failures++; $display("FAIL empty_grant got=%b exp=0000", r); end
    endtask

    task automatic test_back_to_back();
        logic [NP-1:0] r;
        logic [NP*PW-1:0] p;
        refill_req(); refill_rsp(); refill_req();
        do_read(4'b1111, 1'b0, r, p);
        do_read(4'b1111, 1'b1, r, p);
        @(negedge clk);
        checks++; if (i_rst_r !== 1'b1) begin failures++; $display("FAIL net_outst_zero got=%b exp=1", i_rst_r); end
        checks++; if (o_clreq_v !== 1'b1) begin failures++; $display("FAIL net_clreq got=%b exp=1", o_clreq_v); end
        checks++; if (o_ptr !== 5'd0) begin failures++; $display("FAIL net_ptr got=%0d exp=0", o_ptr); end
        @(posedge clk); #1;
        do_read(4'b1111, 1'b0, r, p);
        do_read(4'b1111, 1'b0, r, p);
        checks++; if (r !== 4'b1111) begin failures++; $display("FAIL net_line_kept got=%b exp=1111", r); end
        do_read(4'b1111, 1'b0, r, p);
        checks++; if (r !== 4'b0000) begin failures++; $display("FAIL net_line_gone got=%b exp=0000", r); end
    endtask

    task automatic test_mid_reset();
        logic [NP-1:0] r;
        logic [NP*PW-1:0] p;
        refill_req(); refill_rsp(); refill_req();
        i_rst_v = 1'b1; i_rst_ea_b = 2'd1;
        @(negedge clk);
        checks++; if (i_rst_r !== 1'b0) begin failures++; $display("FAIL mid_rst_r_held got=%b exp=0", i_rst_r); end
        checks++; if (o_clreq_v !== 1'b0) begin failures++; $display("FAIL mid_clreq_held got=%b exp=0", o_clreq_v); end
        checks++; if (o_active !== 1'b1) begin failures++; $display("FAIL mid_active got=%b exp=1", o_active); end
        @(posedge clk); #1;
        do_read(4'b0001, 1'b0, r, p);
        checks++; if (r !== 4'b0001) begin failures++; $display("FAIL mid_read_cont got=%b exp=0001", r); end
        do_read(4'b0000, 1'b1, r, p);
        @(negedge clk);
        checks++; if (i_rst_r !== 1'b1) begin failures++; $display("FAIL mid_rst_accept got=%b exp=1", i_rst_r); end
        @(posedge clk); #1;
        i_rst_v = 1'b0;
        i_rd_v = 4'b1111;
        @(negedge clk);
        checks++; if (o_active !== 1'b0) begin failures++; $display("FAIL mid_fill_active got=%b exp=0", o_active); end
        checks++; if (o_ptr !== 5'd8) begin failures++; $display("FAIL mid_fill_ptr got=%0d exp=8", o_ptr); end
        checks++; if (o_clreq_v !== 1'b1) begin failures++; $display("FAIL mid_fill_clreq got=%b exp=1", o_clreq_v); end
        checks++; if (i_rd_r !== 4'b0000) begin failures++; $display("FAIL mid_fill_grant got=%b exp=0000", i_rd_r); end
        @(posedge clk); #1;
        i_rd_v = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_burst();
        test_wrap();
        test_starve();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
